// File: rtl/lsu_io_buffer_if.sv
// rtl/lsu_io_buffer_if.sv - LSU-side bus between the load/store unit and the I/O buffer
interface lsu_io_buffer_if;
    logic [1:0]  i_sel_lsu;
    logic [31:0] i_lsu_addr;
    logic        i_lsu_wren;
    logic [3:0]  i_bmask;
    logic [31:0] i_st_data;
    logic [31:0] o_ld_data;
    logic        o_unmapped;

    modport master (
        output i_sel_lsu, i_lsu_addr, i_lsu_wren, i_bmask, i_st_data,
        input  o_ld_data, o_unmapped
    );

    modport slave (
        input  i_sel_lsu, i_lsu_addr, i_lsu_wren, i_bmask, i_st_data,
        output o_ld_data, o_unmapped
    );
endinterface

// File: rtl/lsu_io_buffer.sv
// rtl/lsu_io_buffer.sv - MEM-stage I/O buffer: debounced switch/button inputs, byte-writable output registers
module lsu_io_buffer #(
    parameter int SW_W       = 10,
    parameter int BTN_W      = 4,
    parameter int DEB_CYCLES = 50000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    lsu_io_buffer_if.slave    bus,
    input  logic [SW_W-1:0]   i_io_sw,
    input  logic [BTN_W-1:0]  i_io_btn,
    output logic [31:0]       o_io_ledr,
    output logic [31:0]       o_io_ledg,
    output logic [31:0]       o_io_hexl,
    output logic [31:0]       o_io_hexh,
    output logic [31:0]       o_io_lcd
);
    localparam int IN_W  = SW_W + BTN_W;
    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d, hexl_q, hexl_d;
    logic [31:0] hexh_q, hexh_d, lcd_q, lcd_d;
    logic [31:0] ld_q, ld_d;
    logic        unmapped_q, unmapped_d;
    logic [IN_W-1:0]  sync1_q, sync2_q, samp_q, samp_d, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        tick;
    logic [2:0]  idx;
    logic        wr_en;
    logic        unused_addr_bits;

    assign idx   = bus.i_lsu_addr[14:12];
    assign wr_en = bus.i_lsu_wren && (bus.i_sel_lsu == 2'b10) && (idx <= 3'd4);
    assign tick  = (cnt_q == CNT_MAX);
    assign unused_addr_bits = ^{bus.i_lsu_addr[31:15], bus.i_lsu_addr[11:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++)
            if (mask[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        hexl_d = hexl_q;
        hexh_d = hexh_q;
        lcd_d  = lcd_q;
        if (wr_en) begin
            case (idx)
                3'd0:    ledr_d = merge(ledr_q, bus.i_st_data, bus.i_bmask);
                3'd1:    ledg_d = merge(ledg_q, bus.i_st_data, bus.i_bmask);
                3'd2:    hexl_d = merge(hexl_q, bus.i_st_data, bus.i_bmask);
                3'd3:    hexh_d = merge(hexh_q, bus.i_st_data, bus.i_bmask);
                default: lcd_d  = merge(lcd_q,  bus.i_st_data, bus.i_bmask);
            endcase
        end
    end

    // Reads see the registered (pre-write) values, giving read-before-write on collisions.
    always_comb begin
        ld_d = 32'd0;
        case (bus.i_sel_lsu)
            2'b01: ld_d = bus.i_lsu_addr[12] ? 32'(stable_q[IN_W-1:SW_W])
                                             : 32'(stable_q[SW_W-1:0]);
            2'b10: begin
                case (idx)
                    3'd0:    ld_d = ledr_q;
                    3'd1:    ld_d = ledg_q;
                    3'd2:    ld_d = hexl_q;
                    3'd3:    ld_d = hexh_q;
                    3'd4:    ld_d = lcd_q;
                    default: ld_d = 32'd0;
                endcase
            end
            default: ld_d = 32'd0;
        endcase
        unmapped_d = (bus.i_sel_lsu == 2'b11);
    end

    // A bit is accepted only when two consecutive tick samples agree.
    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        samp_d   = samp_q;
        stable_d = stable_q;
        if (tick) begin
            samp_d   = sync2_q;
            stable_d = (sync2_q & ~(sync2_q ^ samp_q)) | (stable_q & (sync2_q ^ samp_q));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            hexl_q     <= '0;
            hexh_q     <= '0;
            lcd_q      <= '0;
            ld_q       <= '0;
            unmapped_q <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            samp_q     <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            hexl_q     <= hexl_d;
            hexh_q     <= hexh_d;
            lcd_q      <= lcd_d;
            ld_q       <= ld_d;
            unmapped_q <= unmapped_d;
            sync1_q    <= {i_io_btn, i_io_sw};
            sync2_q    <= sync1_q;
            samp_q     <= samp_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_ld_data  = ld_q;
    assign bus.o_unmapped = unmapped_q;
    assign o_io_ledr      = ledr_q;
    assign o_io_ledg      = ledg_q;
    assign o_io_hexl      = hexl_q;
    assign o_io_hexh      = hexh_q;
    assign o_io_lcd       = lcd_q;
endmodule

// File: tb/tb_lsu_io_buffer.sv
// tb/tb_lsu_io_buffer.sv - directed self-checking bench for lsu_io_buffer
module tb_lsu_io_buffer;
    logic        i_clk;
    logic        i_reset;
    logic [9:0]  i_io_sw;
    logic [3:0]  i_io_btn;
    logic [31:0] o_io_ledr, o_io_ledg, o_io_hexl, o_io_hexh, o_io_lcd;
    int checks = 0;
    int errors = 0;

    lsu_io_buffer_if bus ();

    lsu_io_buffer #(.SW_W(10), .BTN_W(4), .DEB_CYCLES(4)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .bus       (bus.slave),
        .i_io_sw   (i_io_sw),
        .i_io_btn  (i_io_btn),
        .o_io_ledr (o_io_ledr),
        .o_io_ledg (o_io_ledg),
        .o_io_hexl (o_io_hexl),
        .o_io_hexh (o_io_hexh),
        .o_io_lcd  (o_io_lcd)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] addr, input logic wren,
                         input logic [3:0] mask, input logic [31:0] data);
        bus.i_sel_lsu  = sel;
        bus.i_lsu_addr = addr;
        bus.i_lsu_wren = wren;
        bus.i_bmask    = mask;
        bus.i_st_data  = data;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] r, input logic [31:0] g,
                              input logic [31:0] hl, input logic [31:0] hh, input logic [31:0] l);
        check({tag, "_ledr"}, o_io_ledr, r);
        check({tag, "_ledg"}, o_io_ledg, g);
        check({tag, "_hexl"}, o_io_hexl, hl);
        check({tag, "_hexh"}, o_io_hexh, hh);
        check({tag, "_lcd"},  o_io_lcd,  l);
    endtask

    initial begin
        i_reset  = 1'b0;
        i_io_sw  = '0;
        i_io_btn = '0;
        drive(2'b00, 32'h0, 1'b0, 4'h0, 32'h0);
        step(3);
        check_regs("rst", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("rst_ld", bus.o_ld_data, 32'h0);
        check("rst_unmapped", {31'd0, bus.o_unmapped}, 32'h0);
        i_reset = 1'b1;

        drive(2'b10, 32'h1000_0000, 1'b1, 4'hF, 32'hDEADBEEF);
        step(1);
        check("t1_ledr_full", o_io_ledr, 32'hDEADBEEF);

        drive(2'b10, 32'h1000_0000, 1'b1, 4'h2, 32'h0000AA00);
        step(1);
        check("t2_ledr_byte1", o_io_ledr, 32'hDEADAAEF);

        drive(2'b10, 32'h1000_1000, 1'b1, 4'hF, 32'h0F0F0F0F);
        step(1);
        drive(2'b10, 32'h1000_3000, 1'b1, 4'h5, 32'h12345678);
        step(1);
        check("hexh_mask0101", o_io_hexh, 32'h00340078);

        drive(2'b10, 32'h1000_2000, 1'b1, 4'hF, 32'h11223344);
        step(1);
        drive(2'b10, 32'h1000_2000, 1'b1, 4'hF, 32'h55667788);
        step(1);
        check("t3_rbw_old", bus.o_ld_data, 32'h11223344);
        check("t3_hexl_new", o_io_hexl, 32'h55667788);
        drive(2'b10, 32'h1000_2000, 1'b0, 4'hF, 32'h0);
        step(1);
        check("t3_read_new", bus.o_ld_data, 32'h55667788);

        drive(2'b10, 32'h1000_1000, 1'b0, 4'h1, 32'h0);
        step(1);
        check("read_ledg_mask_ignored", bus.o_ld_data, 32'h0F0F0F0F);
        drive(2'b10, 32'h1000_5000, 1'b0, 4'hF, 32'h0);
        step(1);
        check("read_idx5_zero", bus.o_ld_data, 32'h0);

        drive(2'b00, 32'h1000_0000, 1'b1, 4'hF, 32'h0);
        step(1);
        check("sel00_ld", bus.o_ld_data, 32'h0);
        drive(2'b01, 32'h1000_0000, 1'b1, 4'hF, 32'h0);
        step(1);
        check_regs("sel00_01_nowrite", 32'hDEADAAEF, 32'h0F0F0F0F, 32'h55667788, 32'h00340078, 32'h0);

        drive(2'b11, 32'h1000_0000, 1'b1, 4'hF, 32'hFFFFFFFF);
        step(1);
        check("t5_unmapped_hi", {31'd0, bus.o_unmapped}, 32'h1);
        check("t5_ld_zero", bus.o_ld_data, 32'h0);
        check_regs("t5", 32'hDEADAAEF, 32'h0F0F0F0F, 32'h55667788, 32'h00340078, 32'h0);
        drive(2'b00, 32'h0, 1'b0, 4'h0, 32'h0);
        step(1);
        check("t5_unmapped_lo", {31'd0, bus.o_unmapped}, 32'h0);

        i_io_sw  = 10'h3FF;
        i_io_btn = 4'hA;
        step(20);
        drive(2'b01, 32'h1001_0000, 1'b0, 4'h0, 32'h0);
        step(1);
        check("t4_sw", bus.o_ld_data, 32'h000003FF);
        drive(2'b01, 32'h1001_1000, 1'b0, 4'h0, 32'h0);
        step(1);
        check("t4_btn", bus.o_ld_data, 32'h0000000A);
        i_io_sw = 10'h3FE;
        step(1);
        i_io_sw = 10'h3FF;
        for (int i = 0; i < 12; i++) begin
            drive(2'b01, 32'h1001_0000, 1'b0, 4'h0, 32'h0);
            step(1);
            check("t4_glitch_hold", bus.o_ld_data, 32'h000003FF);
        end
        i_io_sw = 10'h155;
        step(1);
        check("t4_no_instant_change", bus.o_ld_data, 32'h000003FF);
        step(20);
        check("t4_new_value", bus.o_ld_data, 32'h00000155);

        drive(2'b10, 32'h1000_4000, 1'b1, 4'hF, 32'h80000041);
        step(1);
        check("t6_lcd", o_io_lcd, 32'h80000041);
        drive(2'b01, 32'h1001_0000, 1'b0, 4'h0, 32'h0);
        #2;
        i_reset = 1'b0;
        #1;
        check_regs("t6_async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("t6_async_rst_ld", bus.o_ld_data, 32'h0);
        step(2);
        i_reset = 1'b1;
        step(1);
        check("t6_requalify_zero", bus.o_ld_data, 32'h0);
        step(20);
        check("t6_requalified", bus.o_ld_data, 32'h00000155);

        drive(2'b10, 32'h1000_0000, 1'b1, 4'hF, 32'h12345678);
        step(1);
        drive(2'b10, 32'h1000_6000, 1'b1, 4'hF, 32'hFFFFFFFF);
        step(1);
        check_regs("t6_idx6_drop", 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0);
        check("t6_idx6_ld", bus.o_ld_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
